// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM states and the status flag bundle.
package alu_pkg;

    localparam logic [2:0] OP_SUB  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
        logic negative;
    } flags_t;

endpackage

// File: rtl/alu_mul_serial.sv
// Serial shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_serial #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_count;
    logic               r_busy;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b0;
        end else if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, multiplicand};
            r_mplier <= multiplier;
            r_acc    <= '0;
            r_count  <= CW'(WIDTH);
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
                r_busy <= 1'b0;
            end
        end
    end

    // The final step's sum is exposed directly so the caller can register it on the same edge.
    assign busy    = r_busy;
    assign done    = r_busy && (r_count == CW'(1));
    assign product = w_acc_next;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready in and out: single-cycle arithmetic/logic ops plus a serial multiply.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [2:0]       opcode,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] register,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             negative
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_result;
    flags_t             r_flags;

    logic               w_accept;
    logic               w_load;
    logic               w_mul_start;
    logic [WIDTH-1:0]   w_result_next;
    flags_t             w_flags_next;

    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH:0]     w_addsub;
    logic               w_addsub_ovf;
    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_or;
    logic [WIDTH-1:0]   w_xor;
    logic [WIDTH-1:0]   w_op_result;
    logic               w_op_carry;
    logic               w_op_ovf;

    logic               w_mul_busy;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;

    // Opcode bit 0 selects add (1) or subtract (0) on the shared WIDTH+1 bit adder.
    assign w_b_eff      = opcode[0] ? inputB : ~inputB;
    assign w_addsub     = {1'b0, inputA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, ~opcode[0]};
    assign w_addsub_ovf = (inputA[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                          (w_addsub[WIDTH-1] != inputA[WIDTH-1]);

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign w_and[gi] = inputA[gi] & inputB[gi];
        assign w_or[gi]  = inputA[gi] | inputB[gi];
        assign w_xor[gi] = inputA[gi] ^ inputB[gi];
    end

    always_comb begin
        w_op_result = '0;
        w_op_carry  = 1'b0;
        w_op_ovf    = 1'b0;
        case (opcode)
            OP_SUB, OP_ADD: begin
                w_op_result = w_addsub[WIDTH-1:0];
                w_op_carry  = w_addsub[WIDTH];
                w_op_ovf    = w_addsub_ovf;
            end
            OP_AND:  w_op_result = w_and;
            OP_OR:   w_op_result = w_or;
            OP_XOR:  w_op_result = w_xor;
            OP_SLT:  w_op_result = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
            default: w_op_result = '0;
        endcase
    end

    assign inReady  = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && outReady));
    assign w_accept = inValid && inReady;

    alu_mul_serial #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clock        (clock),
        .reset        (reset),
        .start        (w_mul_start),
        .multiplicand (inputA),
        .multiplier   (inputB),
        .busy         (w_mul_busy),
        .done         (w_mul_done),
        .product      (w_product)
    );

    always_comb begin
        w_state_next           = r_state;
        w_load                 = 1'b0;
        w_mul_start            = 1'b0;
        w_result_next          = w_op_result;
        w_flags_next           = '0;
        w_flags_next.carry     = w_op_carry;
        w_flags_next.overflow  = w_op_ovf;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (opcode == OP_MUL) begin
                        w_mul_start  = 1'b1;
                        w_state_next = S_MUL;
                    end else begin
                        w_load       = 1'b1;
                        w_state_next = S_DONE;
                    end
                end else if ((r_state == S_DONE) && outReady) begin
                    w_state_next = S_IDLE;
                end
            end
            S_MUL: begin
                if (w_mul_busy && w_mul_done) begin
                    w_load                = 1'b1;
                    w_result_next         = w_product[WIDTH-1:0];
                    w_flags_next.carry    = 1'b0;
                    w_flags_next.overflow = |w_product[2*WIDTH-1:WIDTH];
                    w_state_next          = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        w_flags_next.zero     = (w_result_next == '0);
        w_flags_next.negative = w_result_next[WIDTH-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_result <= w_result_next;
                r_flags  <= w_flags_next;
            end
        end
    end

    assign outValid = (r_state == S_DONE);
    assign register = r_result;
    assign zero     = r_flags.zero;
    assign carry    = r_flags.carry;
    assign overflow = r_flags.overflow;
    assign negative = r_flags.negative;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's 8-bit add/subtract ALU. It adds logic ops, signed compare, and a multi-cycle shift-add multiply, and reports status flags. Operands enter over a valid/ready handshake, and results leave over a second one. It sits between the operand register file and the result write-back stage.

## Interface
- WIDTH, 8, operand/result width (>= 2)
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- inValid  in  1  operands/opcode valid
- inReady  out  1  block can accept; transfer when inValid && inReady at a rising edge
- inputA  in  WIDTH  operand A
- inputB  in  WIDTH  operand B
- opcode  in  3  operation select
- outValid  out  1  result/flags valid
- outReady  in  1  consumer takes result; transfer when outValid && outReady
- register  out  WIDTH  result
- zero, carry, overflow, negative  out  1 each  status flags for the current result

## Operation
- Opcodes:
  - 000 SUB A-B
  - 001 ADD A+B (bit0 keeps the legacy control meaning: 1 = add, 0 = subtract)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT: 1 if A<B signed, else 0
  - 110 MUL: low WIDTH bits of unsigned A*B
  - 111 reserved: result 0
- Operands and opcode are captured only at acceptance; later input changes are ignored.
- Flags:
  - zero = (result == 0).
  - negative = result[WIDTH-1].
  - ADD: carry = carry-out; overflow = signed overflow.
  - SUB: computed as A + ~B + 1; carry = 1 iff A >= B unsigned (no borrow); overflow = signed overflow.
  - MUL: carry = 0; overflow = 1 iff upper WIDTH bits of the 2*WIDTH product are nonzero.
  - AND/OR/XOR/SLT/reserved: carry = overflow = 0.
- FSM states IDLE, MUL, DONE:
  - IDLE: on accept of a non-MUL op, compute and register result/flags, then go to DONE. On accept of MUL, load the multiplicand (zero-extended to 2*WIDTH), the multiplier, acc = 0 and count = WIDTH, then go to MUL.
  - MUL: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count--. On the step where count reaches 0, register result/flags from acc and go to DONE.
  - DONE: outValid = 1; register and flags are held stable.
    - If outReady and inValid: the handshake accepts the next op in the same cycle.
    - If outReady and no inValid: go to IDLE.
    - If outReady is low: stay in DONE.
- inReady = !reset && (state == IDLE || (state == DONE && outReady)). It is low throughout MUL.

## Timing
- Reset values: state IDLE, outValid 0, register 0, all flags 0, inReady 0 while reset is high.
- A reset asserted in any state, including mid-MUL, aborts the operation without producing output. The block is in IDLE with inReady = 1 on the cycle after reset deasserts.
- Non-MUL latency: accepted at edge k, outValid = 1 from edge k+1.
- MUL latency: accepted at edge k, outValid = 1 from edge k+WIDTH.
- Throughput:
  - Non-MUL ops with outReady held high sustain one result per cycle.
  - MUL sustains one result per WIDTH+1 cycles at best.
- When outValid && !outReady, register, flags and outValid must not change until the transfer.
- Simultaneous output transfer and input acceptance in DONE is legal and loses no data.
- WIDTH arithmetic:
  - The add/sub path is WIDTH+1 bits wide to produce carry.
  - The accumulator is 2*WIDTH bits.
  - The counter is $clog2(WIDTH+1) bits.

## Structure
- Shared package alu_pkg:
  - opcode localparams (OP_SUB … OP_RSVD)
  - state encoding (IDLE/MUL/DONE)
  - a flags bundle typedef
- Natural sub-module: alu_mul_serial.
  - Contains the shift-add datapath with its count and accumulator.
  - Handshake: start/busy/done.
  - Outputs: product[2*WIDTH-1:0].
- The FSM, the combinational single-cycle ops and the output registers stay in alu_seq.

## Test plan
All scenarios use WIDTH = 8.
- ADD 0x7F + 0x01 -> register 0x80, overflow 1, negative 1, carry 0, zero 0. outValid is high exactly 1 cycle after acceptance.
- SUB 0x05 - 0x07 -> 0xFE, carry 0, negative 1. SUB 0x10 - 0x10 -> 0x00, zero 1, carry 1, overflow 0.
- MUL 0x0F * 0x11 -> 0xFF, overflow 0, with outValid exactly 8 cycles after acceptance and inReady low meanwhile. MUL 0x10 * 0x10 -> 0x00, zero 1, overflow 1.
- Backpressure:
  - Hold outReady low 5 cycles -> register and flags stable, inReady low.
  - Then 4 back-to-back ADDs with outReady high -> 4 results on 4 consecutive cycles, in order.
- Reset asserted 3 cycles into a MUL -> outValid 0 and register 0 the next cycle, no spurious result. A following ADD 0x01 + 0x02 -> 0x03.
- With A = 0xF0, B = 0x3C:
  - AND -> 0x30, OR -> 0xFC, XOR -> 0xCC.
  - SLT 0x80 vs 0x01 -> 0x01.
  - Opcode 111 -> 0x00 with zero 1.
